btb_tagged: RTL
===============

Name: btb_tagged

Overview:
Parametrised, tagged branch target buffer for the pipelined 2-bit branch-prediction core, replacing the flat untagged BTB RAM.
- Each direct-mapped entry holds a valid bit, a PC tag, a branch target and a 2-bit saturating direction counter.
- Fetch performs a same-cycle lookup. Execute writes back resolved branch outcomes through an update port.
- Supports a synchronous full flush and keeps a live count of valid entries.

Parameters:
PC_W, 32, PC and target width in bits
INDEX_W, 6, log2 of entry count (default 64 entries)
TAG_W, PC_W-INDEX_W-2, tag width; index = pc[INDEX_W+1:2], tag = pc[PC_W-1:INDEX_W+2]

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_lookup_pc  in  PC_W  fetch-stage PC
o_hit  out  1  valid entry at index with matching tag
o_pred_taken  out  1  o_hit AND counter[1]
o_pred_target  out  PC_W  stored target; forced to 0 when o_hit=0
o_ctr  out  2  counter of indexed entry; 0 when o_hit=0
i_upd_en  in  1  resolved-branch update strobe (one per cycle max)
i_upd_pc  in  PC_W  PC of resolved branch
i_upd_taken  in  1  actual direction
i_upd_target  in  PC_W  actual target
i_flush  in  1  invalidate all entries
o_valid_cnt  out  INDEX_W+1  number of valid entries

Behaviour:
- Storage:
  - valid[], ctr[] in flops, reset by i_rst_n.
  - tag[] and target[] need not be reset; their contents are don't-care while the entry is invalid.
- Reset (async assert, sync deassert in the surrounding design):
  - all valid=0, all ctr=2'b01, o_valid_cnt=0.
  - Lookup outputs are therefore o_hit=0, o_pred_taken=0, o_pred_target=0, o_ctr=0 during and after reset.
  - Reset asserted mid-update discards the update.
- Lookup:
  - Purely combinational from the stored arrays; zero-cycle latency.
  - No write bypass: a lookup in the same cycle as an update to the same index returns the pre-update contents. The new contents are visible from the next cycle.
- Update, evaluated at rising edge when i_upd_en=1 and i_flush=0. hit_u = valid[idx] AND tag[idx]==upd_tag.
  - hit_u and taken: ctr = min(ctr+1, 3); target overwritten with i_upd_target.
  - hit_u and not taken: ctr = max(ctr-1, 0); target unchanged; entry stays valid even at ctr=0.
  - miss and taken: allocate. valid=1, tag=upd_tag, target=i_upd_target, ctr=2'b10 (weakly taken). Replaces any existing entry (conflicting tag) at that index.
  - miss and not taken: no state change.
- o_valid_cnt:
  - +1 only when allocation writes an index whose valid was 0.
  - Replacing a valid conflicting entry leaves the count unchanged.
  - Saturates at 2^INDEX_W; cannot exceed by construction.
- Flush (i_flush=1 at rising edge):
  - all valid=0, o_valid_cnt=0; counters untouched.
  - Flush has priority: a simultaneous i_upd_en is dropped entirely.
- Widths:
  - Counter arithmetic is 2-bit saturating, never wraps.
  - i_upd_pc[1:0] and i_lookup_pc[1:0] are ignored.

Test Plan:
1. Reset then lookup 0x0000_0040 -> o_hit=0, o_pred_taken=0, o_pred_target=0, o_ctr=0, o_valid_cnt=0.
2. Update pc=0x0000_0040 taken target=0x0000_0100 -> next cycle lookup 0x40 gives o_hit=1, o_ctr=2, o_pred_taken=1, target=0x100, o_valid_cnt=1. Same-cycle lookup still gives o_hit=0.
3. Saturation on pc 0x40 (entry at ctr=2):
   - Three taken updates -> ctr=3 and stays 3.
   - Then four not-taken updates -> ctr 2,1,0,0; o_pred_taken=0 from ctr=1 onward; o_hit stays 1.
4. Conflict on index 16: alias pc=0x0000_0140 taken target=0x200 -> lookup 0x140 hits with ctr=2, target=0x200; lookup 0x40 misses; o_valid_cnt remains 1. Not-taken update of uncached pc 0x0000_0080 -> no change, count stays 1.
5. Fill all 64 indices with taken updates -> o_valid_cnt=64. Assert i_flush together with a taken update to pc 0x0000_0004 -> o_valid_cnt=0, every lookup misses including 0x4.
6. Assert i_rst_n=0 asynchronously between clock edges while i_upd_en=1 with 5 valid entries -> outputs clear immediately. After release, o_valid_cnt=0 and lookup of the updated PC misses.

Source files
------------

// File: rtl/btb_tagged_if.sv
// Fetch-lookup, execute-update and flush signals of the tagged branch target buffer.
// The master side is the core; the slave side is btb_tagged.
interface btb_tagged_if #(
  parameter int PC_W    = 32,
  parameter int INDEX_W = 6
);
  logic [PC_W-1:0]  i_lookup_pc;
  logic             o_hit;
  logic             o_pred_taken;
  logic [PC_W-1:0]  o_pred_target;
  logic [1:0]       o_ctr;
  logic             i_upd_en;
  logic [PC_W-1:0]  i_upd_pc;
  logic             i_upd_taken;
  logic [PC_W-1:0]  i_upd_target;
  logic             i_flush;
  logic [INDEX_W:0] o_valid_cnt;

  modport master (
    output i_lookup_pc, i_upd_en, i_upd_pc, i_upd_taken, i_upd_target, i_flush,
    input  o_hit, o_pred_taken, o_pred_target, o_ctr, o_valid_cnt
  );

  modport slave (
    input  i_lookup_pc, i_upd_en, i_upd_pc, i_upd_taken, i_upd_target, i_flush,
    output o_hit, o_pred_taken, o_pred_target, o_ctr, o_valid_cnt
  );
endinterface

// File: rtl/btb_tagged.sv
// Direct-mapped tagged branch target buffer with 2-bit saturating direction counters,
// same-cycle lookup, resolved-branch update port, full flush and a live valid-entry count.
module btb_tagged #(
  parameter int PC_W    = 32,
  parameter int INDEX_W = 6,
  parameter int TAG_W   = PC_W - INDEX_W - 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  btb_tagged_if.slave  bus
);
  localparam int ENTRIES = 1 << INDEX_W;

  logic [ENTRIES-1:0]      valid_q;
  logic [ENTRIES-1:0][1:0] ctr_q;
  logic [TAG_W-1:0]        tag_q    [ENTRIES];
  logic [PC_W-1:0]         target_q [ENTRIES];
  logic [INDEX_W:0]        cnt_q;

  function automatic logic [1:0] ctr_inc_sat(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec_sat(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Lookup reads the stored arrays directly, so an update in the same cycle is not visible yet.
  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit;
  logic [1:0]         lk_ctr;

  assign lk_idx = bus.i_lookup_pc[INDEX_W+1:2];
  assign lk_tag = bus.i_lookup_pc[PC_W-1:INDEX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_ctr = lk_hit ? ctr_q[lk_idx] : 2'b00;

  assign bus.o_hit         = lk_hit;
  assign bus.o_pred_taken  = lk_ctr[1];
  assign bus.o_pred_target = lk_hit ? target_q[lk_idx] : '0;
  assign bus.o_ctr         = lk_ctr;
  assign bus.o_valid_cnt   = cnt_q;

  logic [INDEX_W-1:0] up_idx;
  logic [TAG_W-1:0]   up_tag;
  logic               up_act;
  logic               up_hit;
  logic               up_wr_data;

  assign up_idx     = bus.i_upd_pc[INDEX_W+1:2];
  assign up_tag     = bus.i_upd_pc[PC_W-1:INDEX_W+2];
  assign up_act     = bus.i_upd_en && !bus.i_flush;
  assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_wr_data = up_act && bus.i_upd_taken;

  // Word-aligned PCs: the byte-offset bits carry no information.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bus.i_lookup_pc[1:0], bus.i_upd_pc[1:0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      ctr_q   <= {ENTRIES{2'b01}};
      cnt_q   <= '0;
    end else if (bus.i_flush) begin
      valid_q <= '0;
      cnt_q   <= '0;
    end else if (up_act) begin
      if (up_hit) begin
        ctr_q[up_idx] <= bus.i_upd_taken ? ctr_inc_sat(ctr_q[up_idx]) : ctr_dec_sat(ctr_q[up_idx]);
      end else if (bus.i_upd_taken) begin
        // Allocation evicts any conflicting entry; only a previously empty slot grows the count.
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= 2'b10;
        if (!valid_q[up_idx]) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // Tag and target are meaningless while the entry is invalid, so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (up_wr_data) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= bus.i_upd_target;
    end
  end
endmodule
